bin_to_bcd_seq: RTL and testbench
=================================

// Module: bin_to_bcd_seq
// PURPOSE
//  Sequential, parametrised binary-to-BCD converter (shift-and-add-3, one bit per clock).
//  Converts sensor/ADC readings for the seven-segment display path with a start/done handshake.
//  Adds optional two's-complement input (sign flag out) and a significant-digit count for blanking.
//  Sits between the measurement datapath and the display scan/driver logic.
// PARAMETERS
//  BIN_W   16  binary input width (>=2)
//  DIGITS  5   BCD digits out; elaboration error if 10**DIGITS <= 2**BIN_W - 1
//  SIGNED  0   0: bin_code unsigned; 1: bin_code two's complement, magnitude converted
// PORTS
//  clk        in   1           system clock, all logic on rising edge
//  rst_n      in   1           asynchronous active-low reset
//  start      in   1           request conversion of bin_code; honoured only when busy=0
//  bin_code   in   BIN_W       value to convert, sampled on the accepting edge only
//  busy       out  1           conversion in progress
//  done       out  1           one-cycle pulse: bcd_code/neg/nz_digits updated
//  bcd_code   out  4*DIGITS    result, digit 0 in [3:0]; held until next done
//  neg        out  1           1 when SIGNED=1 and the input was negative; 0 otherwise
//  nz_digits  out  clog2(DIGITS+1)  significant digits (leading-zero count removed), 1 for value 0
// BEHAVIOUR
//  - Reset (async, rst_n=0): busy=0, done=0, bcd_code=0, neg=0, nz_digits=1, counter=0, FSM=IDLE.
//  - Interface: clk (rising edge), rst_n (asynchronous, active-low).
//  - FSM: IDLE -> SHIFT on start&&!busy; SHIFT -> IDLE when bit counter reaches BIN_W.
//  - Accept edge E0: load magnitude into shift reg low part, BCD part = 0, counter=0, busy=1.
//    Magnitude: SIGNED=0 -> bin_code; SIGNED=1 -> msb ? -bin_code : bin_code (BIN_W bits unsigned;
//    most-negative value gives 2**(BIN_W-1), which fits). Sign stored in a pending-neg flop.
//  - Edges E1..E_BIN_W: each digit >=5 gets +3, then whole reg shifts left 1; counter++.
//  - At E_BIN_W: bcd_code, neg, nz_digits registered; done=1 for exactly one cycle; busy=0.
//    Latency: start-sampled edge to done high = BIN_W clocks. Throughput: one result per BIN_W+1 clocks.
//  - start while busy=1: ignored, no queuing; bin_code changes during busy: no effect.
//  - start in the done cycle (busy=0): accepted; outputs keep old result until the next done.
//  - nz_digits = index of highest non-zero digit + 1; 1 if all digits zero.
//  - No overflow possible by parameter check; digits above the value are 0.
//  - Reset mid-conversion: aborts immediately, reset values above, no done pulse.
//  - Outputs are registered; no combinational path from start/bin_code to any output.
// STRUCTURE
//  - Package bcd_pkg: typedef bcd_digit_t (logic [3:0]); function min_digits(width) for the
//    parameter check; localparam CNT_W = clog2(BIN_W+1); FSM state enum {IDLE, SHIFT}.
//  - Sub-module bcd_dabble_step (combinational): one add-3-then-shift iteration over DIGITS
//    digits; instanced once, output fed back to the shift register each SHIFT cycle.
//  - Top: FSM, bit counter, shift register (4*DIGITS+BIN_W), sign/magnitude, leading-zero detect.
// TESTING
//  1. Default params, bin_code=16'hFFFF, start 1 cycle -> done 16 clocks later, bcd_code=20'h65535, nz_digits=5.
//  2. bin_code=0 -> bcd_code=0, nz_digits=1, neg=0; bin_code=1234 -> 20'h01234, nz_digits=4.
//  3. SIGNED=1, BIN_W=8, DIGITS=3: 8'h80 -> 12'h128, neg=1; 8'h7F -> 12'h127, neg=0; 8'hFF -> 12'h001, neg=1.
//  4. start pulsed at accept+3 with a different bin_code -> ignored, single done, first value's result.
//  5. rst_n low at accept+5 -> busy=0, bcd_code=0, no done; new start after release converts normally.
//  6. BIN_W=12, DIGITS=4: back-to-back starts over all 4096 values -> each result matches reference
//     model, one done per BIN_W+1 clocks, bcd_code stable between done pulses.

Source files
------------

// File: rtl/bcd_pkg.sv
// ============================================================================
//  Module   : bcd_pkg
//  Brief    : Shared types and helpers for the sequential binary-to-BCD path.
//  Revision : 1.0
// ============================================================================
`default_nettype none

package bcd_pkg;

    typedef logic [3:0] bcd_digit_t;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Smallest digit count d with 10**d > 2**width - 1.
    function automatic int min_digits(input int width);
        longint unsigned max_val;
        longint unsigned pow;
        int              d;
        max_val = (64'd1 << width) - 64'd1;
        pow     = 64'd1;
        d       = 0;
        for (int i = 0; i < 20; i++) begin
            if (pow <= max_val) begin
                pow = pow * 64'd10;
                d   = d + 1;
            end
        end
        return d;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_dabble_step.sv
// ============================================================================
//  Module   : bcd_dabble_step
//  Brief    : One combinational add-3-then-shift iteration over the BCD field.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module bcd_dabble_step
    import bcd_pkg::*;
#(
    parameter int BIN_W  = 16,
    parameter int DIGITS = 5
) (
    input  logic [4*DIGITS+BIN_W-1:0] sh_i,
    output logic [4*DIGITS+BIN_W-1:0] sh_o
);

    localparam int SH_W = 4*DIGITS + BIN_W;

    logic [SH_W-1:0] adj;

    assign adj[BIN_W-1:0] = sh_i[BIN_W-1:0];

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_digit_t dig;
        assign dig = sh_i[BIN_W+4*g +: 4];
        assign adj[BIN_W+4*g +: 4] = (dig >= 4'd5) ? (dig + 4'd3) : dig;
    end

    assign sh_o = adj << 1;

endmodule

`default_nettype wire

// File: rtl/bin_to_bcd_seq.sv
// ============================================================================
//  Module   : bin_to_bcd_seq
//  Brief    : Sequential shift-and-add-3 binary-to-BCD converter, one bit/clock,
//             with optional two's-complement input and significant-digit count.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module bin_to_bcd_seq
    import bcd_pkg::*;
#(
    parameter int BIN_W  = 16,
    parameter int DIGITS = 5,
    parameter int SIGNED = 0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [BIN_W-1:0]             bin_code,
    output logic                         busy,
    output logic                         done,
    output logic [4*DIGITS-1:0]          bcd_code,
    output logic                         neg,
    output logic [$clog2(DIGITS+1)-1:0]  nz_digits
);

    localparam int SH_W  = 4*DIGITS + BIN_W;
    localparam int CNT_W = $clog2(BIN_W+1);
    localparam int NZ_W  = $clog2(DIGITS+1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W-1);

    if (BIN_W < 2 || DIGITS < min_digits(BIN_W)) begin : g_param_check
        $error("bin_to_bcd_seq: DIGITS too small for BIN_W (or BIN_W < 2)");
    end

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [SH_W-1:0]   sh_q, sh_d;
    logic              neg_pend_q, neg_pend_d;
    logic [4*DIGITS-1:0] bcd_q, bcd_d;
    logic              neg_q, neg_d;
    logic [NZ_W-1:0]   nz_q, nz_d;
    logic              done_q, done_d;

    logic [SH_W-1:0]   step_out;
    logic              in_neg;
    logic [BIN_W-1:0]  mag;
    logic [NZ_W-1:0]   nz_next;

    bcd_dabble_step #(
        .BIN_W  (BIN_W),
        .DIGITS (DIGITS)
    ) u_step (
        .sh_i (sh_q),
        .sh_o (step_out)
    );

    // Most-negative input negates to 2**(BIN_W-1), which still fits unsigned.
    assign in_neg = (SIGNED != 0) && bin_code[BIN_W-1];
    assign mag    = in_neg ? (~bin_code + BIN_W'(1)) : bin_code;

    always_comb begin
        nz_next = NZ_W'(1);
        for (int i = 0; i < DIGITS; i++) begin
            if (step_out[BIN_W+4*i +: 4] != 4'd0) begin
                nz_next = NZ_W'(i + 1);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sh_d       = sh_q;
        neg_pend_d = neg_pend_q;
        bcd_d      = bcd_q;
        neg_d      = neg_q;
        nz_d       = nz_q;
        done_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = SHIFT;
                    sh_d       = {{(4*DIGITS){1'b0}}, mag};
                    cnt_d      = '0;
                    neg_pend_d = in_neg;
                end
            end
            SHIFT: begin
                sh_d  = step_out;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    state_d = IDLE;
                    bcd_d   = step_out[SH_W-1 -: 4*DIGITS];
                    neg_d   = neg_pend_q;
                    nz_d    = nz_next;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            sh_q       <= '0;
            neg_pend_q <= 1'b0;
            bcd_q      <= '0;
            neg_q      <= 1'b0;
            nz_q       <= NZ_W'(1);
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sh_q       <= sh_d;
            neg_pend_q <= neg_pend_d;
            bcd_q      <= bcd_d;
            neg_q      <= neg_d;
            nz_q       <= nz_d;
            done_q     <= done_d;
        end
    end

    assign busy      = (state_q == SHIFT);
    assign done      = done_q;
    assign bcd_code  = bcd_q;
    assign neg       = neg_q;
    assign nz_digits = nz_q;

endmodule

`default_nettype wire

// File: tb/tb_bin_to_bcd_seq.sv
// ============================================================================
//  Module   : tb_bin_to_bcd_seq
//  Brief    : Scoreboard bench for three converter configurations
//             (16b/5d unsigned, 8b/3d signed, 12b/4d unsigned).
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_bin_to_bcd_seq;

    localparam int BW [3] = '{16, 8, 12};
    localparam int DG [3] = '{5, 3, 4};
    localparam int SG [3] = '{0, 1, 0};

    typedef struct {
        logic [31:0] bcd;
        logic        neg;
        logic [3:0]  nz;
        longint      acc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  start_r = '0;
    logic [15:0] code_r [3];
    logic [2:0]  busy_w, done_w, neg_w;
    logic [19:0] bcd0;
    logic [11:0] bcd1;
    logic [15:0] bcd2;
    logic [2:0]  nz0;
    logic [1:0]  nz1;
    logic [2:0]  nz2;
    logic [31:0] bcd_w [3];
    logic [3:0]  nz_w  [3];

    exp_t        sb [3][$];
    longint      cyc = 0;
    int          n_checks = 0;
    int          n_errors = 0;
    int          ndone [3] = '{0, 0, 0};
    longint      last_done [3];
    logic [31:0] held [3] = '{0, 0, 0};
    logic        unstable [3] = '{0, 0, 0};
    logic        b2b = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bin_to_bcd_seq #(.BIN_W(16), .DIGITS(5), .SIGNED(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start_r[0]), .bin_code(code_r[0]),
        .busy(busy_w[0]), .done(done_w[0]), .bcd_code(bcd0), .neg(neg_w[0]), .nz_digits(nz0));
    bin_to_bcd_seq #(.BIN_W(8), .DIGITS(3), .SIGNED(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start_r[1]), .bin_code(code_r[1][7:0]),
        .busy(busy_w[1]), .done(done_w[1]), .bcd_code(bcd1), .neg(neg_w[1]), .nz_digits(nz1));
    bin_to_bcd_seq #(.BIN_W(12), .DIGITS(4), .SIGNED(0)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start_r[2]), .bin_code(code_r[2][11:0]),
        .busy(busy_w[2]), .done(done_w[2]), .bcd_code(bcd2), .neg(neg_w[2]), .nz_digits(nz2));

    assign bcd_w[0] = {12'd0, bcd0};
    assign bcd_w[1] = {20'd0, bcd1};
    assign bcd_w[2] = {16'd0, bcd2};
    assign nz_w[0]  = {1'b0, nz0};
    assign nz_w[1]  = {2'b0, nz1};
    assign nz_w[2]  = {1'b0, nz2};

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference by repeated division, independent of the shift-and-add-3 method.
    function automatic exp_t model(input int k, input logic [15:0] code, input longint acc);
        exp_t e;
        int   v;
        int   dig;
        v     = int'(code) & ((1 << BW[k]) - 1);
        e.bcd = '0;
        e.neg = 1'b0;
        e.nz  = 4'd1;
        e.acc = acc;
        if (SG[k] != 0 && v >= (1 << (BW[k] - 1))) begin
            v     = (1 << BW[k]) - v;
            e.neg = 1'b1;
        end
        for (int d = 0; d < DG[k]; d++) begin
            dig = v % 10;
            e.bcd[4*d +: 4] = 4'(dig);
            if (dig != 0) e.nz = 4'(d + 1);
            v = v / 10;
        end
        return e;
    endfunction

    // Called at a negedge; waits for idle, drives a one-cycle start and logs the expectation.
    task automatic convert(input int k, input logic [15:0] code);
        int t;
        t = 0;
        while (busy_w[k] && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (busy_w[k]) check_val("busy_timeout", 64'(busy_w[k]), 64'd0);
        start_r[k] = 1'b1;
        code_r[k]  = code;
        sb[k].push_back(model(k, code, cyc + 1));
        @(negedge clk);
        start_r[k] = 1'b0;
        code_r[k]  = 16'hDEAD;
    endtask

    task automatic wait_idle(input int k);
        int t;
        t = 0;
        while ((sb[k].size() != 0 || busy_w[k]) && t < 300) begin
            @(negedge clk);
            t++;
        end
        check_val("drain_timeout", 64'(sb[k].size()), 64'd0);
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (!rst_n) begin
                held[k]     = '0;
                unstable[k] = 1'b0;
            end else if (done_w[k]) begin
                if (sb[k].size() == 0) begin
                    check_val("unexpected_done", 64'(k), 64'hFF);
                end else begin
                    exp_t e;
                    e = sb[k].pop_front();
                    check_val("bcd_code",  64'(bcd_w[k]), 64'(e.bcd));
                    check_val("neg",       64'(neg_w[k]), 64'(e.neg));
                    check_val("nz_digits", 64'(nz_w[k]),  64'(e.nz));
                    check_val("latency",   64'(cyc - e.acc), 64'(BW[k]));
                    check_val("held_stable", 64'(unstable[k]), 64'd0);
                    check_val("busy_in_done", 64'(busy_w[k]), 64'd0);
                    if (k == 2 && b2b && ndone[2] > 0)
                        check_val("interval", 64'(cyc - last_done[2]), 64'(BW[2] + 1));
                end
                ndone[k]++;
                last_done[k] = cyc;
                held[k]      = bcd_w[k];
                unstable[k]  = 1'b0;
            end else if (bcd_w[k] !== held[k]) begin
                unstable[k] = 1'b1;
            end
        end
    end

    initial begin
        int nd;
        code_r = '{16'd0, 16'd0, 16'd0};
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check_val("rst_busy", 64'(busy_w[k]), 64'd0);
            check_val("rst_done", 64'(done_w[k]), 64'd0);
            check_val("rst_bcd",  64'(bcd_w[k]),  64'd0);
            check_val("rst_neg",  64'(neg_w[k]),  64'd0);
            check_val("rst_nz",   64'(nz_w[k]),   64'd1);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Unsigned 16-bit patterns including extremes.
        convert(0, 16'hFFFF);
        convert(0, 16'd0);
        convert(0, 16'd1234);
        convert(0, 16'd10000);
        convert(0, 16'd9);
        for (int i = 0; i < 6; i++) convert(0, 16'($urandom));
        wait_idle(0);

        // Signed 8-bit: most-negative, max positive, -1, zero, -100.
        convert(1, 16'h0080);
        convert(1, 16'h007F);
        convert(1, 16'h00FF);
        convert(1, 16'h0000);
        convert(1, 16'h009C);
        wait_idle(1);

        // Start while busy is ignored.
        nd = ndone[0];
        convert(0, 16'd4321);
        repeat (2) @(negedge clk);
        start_r[0] = 1'b1;
        code_r[0]  = 16'd9999;
        @(negedge clk);
        start_r[0] = 1'b0;
        wait_idle(0);
        repeat (25) @(negedge clk);
        check_val("single_done", 64'(ndone[0] - nd), 64'd1);

        // Reset mid-conversion aborts with no done.
        convert(0, 16'd5555);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_val("abort_busy", 64'(busy_w[0]), 64'd0);
        check_val("abort_done", 64'(done_w[0]), 64'd0);
        check_val("abort_bcd",  64'(bcd_w[0]),  64'd0);
        check_val("abort_nz",   64'(nz_w[0]),   64'd1);
        sb[0].delete();
        nd = ndone[0];
        @(negedge clk);
        rst_n = 1'b1;
        repeat (25) @(negedge clk);
        check_val("abort_no_done", 64'(ndone[0] - nd), 64'd0);
        convert(0, 16'd9);
        convert(0, 16'd65530);
        wait_idle(0);

        // 12-bit exhaustive, back-to-back.
        b2b = 1'b1;
        for (int v = 0; v < 4096; v++) convert(2, 16'(v));
        wait_idle(2);
        b2b = 1'b0;
        check_val("exh_count", 64'(ndone[2]), 64'd4096);

        repeat (5) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
